// File: rtl/circuit_1_sequencer.sv
// Sweeps circuit_1 inputs {a,b,c} through 000..111, waits SETTLE_CYCLES per vector, samples o_dut
// and scores it against EXPECT. Optional build macro: SEQ_STOP_ON_FAIL_EN (end sweep on first mismatch).
module circuit_1_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 22,
  parameter logic [7:0]  EXPECT        = 8'hAB
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       o_dut_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [3:0] err_cnt_o,
  output logic [2:0] fail_idx_o,
  output logic [7:0] sampled_o
);

  localparam int unsigned    CntW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      vec_q, vec_d;
  logic [2:0]      vecIdx_q, vecIdx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [3:0]      errCnt_q, errCnt_d;
  logic [2:0]      failIdx_q, failIdx_d;
  logic [7:0]      sampled_q, sampled_d;
  logic            mismatch;
  logic            lastVec;

  assign mismatch = (o_dut_i != EXPECT[vecIdx_q]);
  assign lastVec  = (vecIdx_q == 3'd7);

  // Sweep control; the driven vector is tracked apart from vecIdx so it can return to 000 on exit
  // while the partial results stay indexed where the sweep stopped.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    vecIdx_d  = vecIdx_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    errCnt_d  = errCnt_q;
    failIdx_d = failIdx_q;
    sampled_d = sampled_q;

    case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          vec_d     = 3'd0;
          vecIdx_d  = 3'd0;
          cnt_d     = '0;
          errCnt_d  = 4'd0;
          failIdx_d = 3'd0;
          sampled_d = 8'd0;
          pass_d    = 1'b0;
          state_d   = StSettle;
        end
      end

      StSettle: begin
        if (abort_i) begin
          pass_d  = 1'b0;
          vec_d   = 3'd0;
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StSample: begin
        if (abort_i) begin
          pass_d  = 1'b0;
          vec_d   = 3'd0;
          state_d = StIdle;
        end else begin
          sampled_d[vecIdx_q] = o_dut_i;
          // errCnt still zero means this is the first mismatch of the sweep
          if (mismatch) begin
            errCnt_d = errCnt_q + 4'd1;
            if (errCnt_q == 4'd0) begin
              failIdx_d = vecIdx_q;
            end
          end
`ifdef SEQ_STOP_ON_FAIL_EN
          if (lastVec || mismatch) begin
`else
          if (lastVec) begin
`endif
            state_d = StDone;
          end else begin
            vecIdx_d = vecIdx_q + 3'd1;
            vec_d    = vecIdx_q + 3'd1;
            cnt_d    = '0;
            state_d  = StSettle;
          end
        end
      end

      StDone: begin
        done_d  = 1'b1;
        pass_d  = (errCnt_q == 4'd0);
        vec_d   = 3'd0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StSettle) || (state_d == StSample);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      vec_q     <= 3'd0;
      vecIdx_q  <= 3'd0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      errCnt_q  <= 4'd0;
      failIdx_q <= 3'd0;
      sampled_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      vecIdx_q  <= vecIdx_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      errCnt_q  <= errCnt_d;
      failIdx_q <= failIdx_d;
      sampled_q <= sampled_d;
    end
  end

  assign a_o        = vec_q[2];
  assign b_o        = vec_q[1];
  assign c_o        = vec_q[0];
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign err_cnt_o  = errCnt_q;
  assign fail_idx_o = failIdx_q;
  assign sampled_o  = sampled_q;

endmodule

// File: tb/tb_circuit_1_sequencer.sv
// Bench for circuit_1_sequencer: a delay-line model of circuit_1 feeds o_dut; sweeps are scored
// against a truth-table reference (popcount/first-set-bit of the difference from the golden table).
module tb_circuit_1_sequencer;

  localparam logic [7:0] Golden       = 8'hAB;
  localparam int         SettleCycles = 22;

  typedef struct {
    logic [7:0] tbl;
    logic [7:0] expSampled;
    logic [3:0] expErr;
    logic [2:0] expIdx;
    logic       expPass;
  } vector_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       oDut;
  logic       a, b, c, busy, done, pass;
  logic [3:0] errCnt;
  logic [2:0] failIdx;
  logic [7:0] sampled;

  logic       fStart;
  logic       fODut;
  logic       fA, fB, fC, fBusy, fDone, fPass;
  logic [3:0] fErrCnt;
  logic [2:0] fFailIdx;
  logic [7:0] fSampled;

  logic [7:0]  circuitTable;
  logic [4:0]  tapSel;
  logic [31:0] pipe;
  logic [31:0] fPipe;

  int checkCount = 0;
  int errorCount = 0;

  vector_t vectors [6];

  circuit_1_sequencer #(.SETTLE_CYCLES(SettleCycles), .EXPECT(Golden)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .o_dut_i(oDut),
    .a_o(a), .b_o(b), .c_o(c), .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_cnt_o(errCnt), .fail_idx_o(failIdx), .sampled_o(sampled)
  );

  circuit_1_sequencer #(.SETTLE_CYCLES(1), .EXPECT(Golden)) dutFast (
    .clk_i(clk), .rst_i(rst), .start_i(fStart), .abort_i(1'b0), .o_dut_i(fODut),
    .a_o(fA), .b_o(fB), .c_o(fC), .busy_o(fBusy), .done_o(fDone), .pass_o(fPass),
    .err_cnt_o(fErrCnt), .fail_idx_o(fFailIdx), .sampled_o(fSampled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // circuit_1 stand-in: truth table followed by a transport delay of tapSel+1 clocks
  always @(posedge clk) begin
    pipe  <= {pipe[30:0], circuitTable[{a, b, c}]};
    fPipe <= {fPipe[30:0], circuitTable[{fA, fB, fC}]};
  end
  assign oDut  = pipe[tapSel];
  assign fODut = fPipe[21];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Expected scoring of one sweep when the circuit reliably shows tbl
  function automatic void refSweep(input logic [7:0] tbl, output logic [7:0] expS,
                                   output logic [3:0] expE, output logic [2:0] expI, output logic expP);
    logic [7:0] diff;
    logic       found;
    diff  = tbl ^ Golden;
    found = 1'b0;
    expE  = 4'd0;
    expI  = 3'd0;
    expS  = tbl;
    for (int k = 0; k < 8; k++) begin
      if (diff[k]) begin
        if (!found) expI = 3'(k);
        found = 1'b1;
        expE  = expE + 4'd1;
      end
    end
`ifdef SEQ_STOP_ON_FAIL_EN
    if (found) begin
      expE = 4'd1;
      expS = tbl & ((8'd2 << expI) - 8'd1);
    end
`endif
    expP = (expE == 4'd0);
  endfunction

  function automatic int expDone(input int settle, input logic [3:0] expE, input logic [2:0] expI);
`ifdef SEQ_STOP_ON_FAIL_EN
    if (expE != 4'd0) return (int'(expI) + 1) * (settle + 1) + 1;
`endif
    return 8 * (settle + 1) + 1 + 0 * int'(expE) + 0 * int'(expI);
  endfunction

  // One sweep against the main instance; optionally re-pulses start at cycle extraStartAt
  task automatic applyStimulus(input logic [7:0] tbl, input int extraStartAt,
                               input logic [7:0] expS, input logic [3:0] expE,
                               input logic [2:0] expI, input logic expP);
    int cycles;
    circuitTable = tbl;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("pass_cleared", 32'(pass), 32'd0);
    cycles = 0;
    while (!done && cycles < 400) begin
      start = (cycles == extraStartAt);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    checkOutput("done_cycle", cycles, expDone(SettleCycles, expE, expI));
    checkOutput("sampled", 32'(sampled), 32'(expS));
    checkOutput("err_cnt", 32'(errCnt), 32'(expE));
    checkOutput("fail_idx", 32'(failIdx), 32'(expI));
    checkOutput("pass", 32'(pass), 32'(expP));
    checkOutput("abc_idle", 32'({a, b, c, busy}), 32'd0);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("pass_held", 32'(pass), 32'(expP));
  endtask

  initial begin
    logic [7:0] rS;
    logic [3:0] rE;
    logic [2:0] rI;
    logic       rP;
    logic [7:0] tbl;
    int         n;
    int         doneSeen;

`ifdef SEQ_STOP_ON_FAIL_EN
    vectors[0] = '{8'hAB, 8'hAB, 4'd0, 3'd0, 1'b1};
    vectors[1] = '{8'h00, 8'h00, 4'd1, 3'd0, 1'b0};
    vectors[2] = '{8'hFF, 8'h07, 4'd1, 3'd2, 1'b0};
    vectors[3] = '{8'hAA, 8'h00, 4'd1, 3'd0, 1'b0};
    vectors[4] = '{8'h2B, 8'h2B, 4'd1, 3'd7, 1'b0};
    vectors[5] = '{8'hEB, 8'h6B, 4'd1, 3'd6, 1'b0};
`else
    vectors[0] = '{8'hAB, 8'hAB, 4'd0, 3'd0, 1'b1};
    vectors[1] = '{8'h00, 8'h00, 4'd5, 3'd0, 1'b0};
    vectors[2] = '{8'hFF, 8'hFF, 4'd3, 3'd2, 1'b0};
    vectors[3] = '{8'hAA, 8'hAA, 4'd1, 3'd0, 1'b0};
    vectors[4] = '{8'h2B, 8'h2B, 4'd1, 3'd7, 1'b0};
    vectors[5] = '{8'hEB, 8'hEB, 4'd1, 3'd6, 1'b0};
`endif

    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    fStart       = 1'b0;
    circuitTable = Golden;
    tapSel       = 5'd21;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 32'({a, b, c, busy, done, pass, errCnt, failIdx, sampled}), 32'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    $display("[TB] table-driven sweeps");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vectors[i].tbl, -1, vectors[i].expSampled, vectors[i].expErr,
                    vectors[i].expIdx, vectors[i].expPass);
    end

    $display("[TB] randomized sweeps");
    for (int i = 0; i < 12; i++) begin
      tbl    = ($urandom_range(0, 3) == 0) ? Golden : 8'($urandom);
      tapSel = 5'($urandom_range(0, 21));
      refSweep(tbl, rS, rE, rI, rP);
      applyStimulus(tbl, (i % 2 == 0) ? int'($urandom_range(1, 180)) : 50, rS, rE, rI, rP);
    end
    tapSel = 5'd21;

    $display("[TB] start and abort together in idle");
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_idle", 32'(busy), 32'd0);

    $display("[TB] abort during settle");
    circuitTable = Golden;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_settle_busy", 32'(busy), 32'd0);

    $display("[TB] abort in the sample cycle of vector 3");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ({a, b, c} != 3'd3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_vec3", 32'(n < 200), 32'd1);
    repeat (SettleCycles) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy_abc", 32'({busy, a, b, c}), 32'd0);
    checkOutput("abort_sampled", 32'(sampled), 32'h03);
    checkOutput("abort_err_pass", 32'({errCnt, pass}), 32'd0);
    doneSeen = 0;
    repeat (200) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("abort_no_done", doneSeen, 0);

    $display("[TB] reset in the middle of a sweep");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reset_mid_sweep", 32'({a, b, c, busy, done, pass, errCnt, failIdx, sampled}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    repeat (200) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("reset_no_done", doneSeen, 0);

    $display("[TB] settle time shorter than the circuit delay");
    // Every sample lands before the 22-clock path delay, so each vector reads vector 0's output
    refSweep(circuitTable[0] ? 8'hFF : 8'h00, rS, rE, rI, rP);
    fStart = 1'b1;
    @(negedge clk);
    fStart = 1'b0;
    n = 0;
    while (!fDone && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fast_done_cycle", n, expDone(1, rE, rI));
    checkOutput("fast_err_cnt", 32'(fErrCnt), 32'(rE));
    checkOutput("fast_err_nonzero", 32'(fErrCnt != 4'd0), 32'd1);
    checkOutput("fast_sampled", 32'(fSampled), 32'(rS));
    checkOutput("fast_fail_idx", 32'(fFailIdx), 32'(rI));
    checkOutput("fast_pass_busy", 32'({fPass, fBusy}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
